key_led_ctrl: RTL
=================

// Module: key_led_ctrl
// PURPOSE
//   Multi-channel push-button to LED controller; parametrised successor of the
//   single key->led path. Per channel: synchronise, debounce, detect the press
//   edge, drive the LED in one of four runtime-selectable modes. Sits between
//   the board key pins and the LED pins; key_press pulses feed other logic.
// PARAMETERS
//   CH            4          number of key/LED channels (1..16)
//   DEBOUNCE_CYC  1_000_000  stable cycles to accept a key level (20 ms @ 50 MHz), >=2
//   BLINK_CYC     25_000_000 half-period of blink mode in cycles, >=2
//   KEY_ACT_LOW   1          1: key pin reads 0 when pressed; 0: reads 1 when pressed
// PORTS
//   sys_clk    in   1      single clock
//   sys_rst    in   1      synchronous, active-high reset
//   key        in   CH     raw asynchronous key pins
//   mode       in   2*CH   per-channel mode, bits [2i+1:2i] for channel i
//   led        out  CH     LED drive, 1 = lit
//   key_state  out  CH     debounced level, 1 = pressed
//   key_press  out  CH     one-cycle pulse on debounced press edge
// BEHAVIOUR
//   Reset: led=0, key_state=0, key_press=0, all counters 0, sync flops and
//     debounced level preset to the released level (no press pulse after reset).
//   Sync: 2-flop synchroniser per channel, then polarity normalised (1 = pressed).
//   Debounce: cnt increments each cycle sync != key_state, clears when equal;
//     when cnt == DEBOUNCE_CYC-1 and still different: key_state <= sync, cnt <= 0.
//     Pin change -> key_state change latency = 2 + DEBOUNCE_CYC cycles.
//     Any glitch shorter than DEBOUNCE_CYC cycles produces no change.
//     cnt width = $clog2(DEBOUNCE_CYC); never wraps.
//   key_press: high exactly one cycle after key_state goes 0->1; none on release.
//   Modes (encodings in package):
//     MODE_FOLLOW 2'b00  led = key_state (registered, 1 cycle after key_state)
//     MODE_TOGGLE 2'b01  led inverts on each key_press
//     MODE_BLINK  2'b10  key_press toggles blink_en; while blink_en, led follows
//                        shared blink phase; blink_en=0 -> led=0
//     MODE_OFF    2'b11  led = 0; presses still reported on key_press
//   Blink prescaler: one shared counter 0..BLINK_CYC-1; phase inverts on wrap.
//     Free-running from reset, so channels in blink mode are phase-aligned.
//   Mode change: when mode[i] differs from its registered copy, channel i clears
//     toggle state and blink_en in that cycle; led follows the new mode next cycle.
//     A key_press in the same cycle as a mode change is ignored for LED state
//     but still appears on key_press.
//   Reset mid-debounce or mid-blink: all state returns to reset values in 1 cycle.
//   Channels are fully independent apart from the shared blink phase.
// STRUCTURE
//   Package key_led_pkg: MODE_FOLLOW/TOGGLE/BLINK/OFF localparams, 2-bit mode width.
//   Sub-module key_debounce (sync + debounce + press edge, one channel, params
//     DEBOUNCE_CYC, KEY_ACT_LOW), instantiated CH times via generate.
//   Top holds the blink prescaler, mode registers and per-channel LED logic.
// TESTING (bench with CH=4, DEBOUNCE_CYC=4, BLINK_CYC=8, KEY_ACT_LOW=1)
//   Reset with key=4'b1111 held -> led=0, key_state=0, no key_press for 20 cycles.
//   ch0 FOLLOW, key[0]=0 held 10 cycles -> key_state[0]=1 at cycle 6, key_press[0]
//     one pulse at cycle 7, led[0]=1 at cycle 7; release -> led[0]=0 after 7 cycles.
//   ch1 TOGGLE, 3-cycle low glitch -> no change; three clean presses -> led[1]=1,0,1.
//   ch2 BLINK, one press -> led[2] toggles every 8 cycles; second press -> led[2]=0.
//   ch3 BLINK enabled, switch mode to OFF then TOGGLE -> led[3]=0, blink_en cleared.
//   Assert sys_rst mid-debounce (cnt=2) -> key_state stays 0, no key_press pulse.

Source files
------------

// File: rtl/key_led_pkg.sv
// key_led_pkg
//   Shared definitions for the key/LED controller: LED mode encodings and
//   the width of one channel's mode field.
package key_led_pkg;

  localparam int MODE_W = 2;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_FOLLOW = 2'b00;  // led mirrors debounced key level
  localparam mode_t MODE_TOGGLE = 2'b01;  // each press inverts led
  localparam mode_t MODE_BLINK  = 2'b10;  // each press starts/stops blinking
  localparam mode_t MODE_OFF    = 2'b11;  // led dark, presses still reported

endpackage

// File: rtl/key_debounce.sv
// key_debounce
//   One key channel: 2-flop synchroniser, polarity normalisation, counter
//   debouncer and press-edge strobe.
// Ports
//   clk        clock
//   rst        synchronous active-high reset
//   key        raw asynchronous key pin
//   key_state  debounced level, 1 = pressed
//   key_press  one-cycle strobe, high the cycle after key_state rises
// key_press is a plain strobe with no handshake: consumers must sample it in
// the cycle it is high; it is never held or repeated.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter bit KEY_ACT_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic key_state,
  output logic key_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  // Pin level that corresponds to "released"; the synchroniser resets to it so
  // that leaving reset never looks like a press.
  localparam logic KEY_REL = KEY_ACT_LOW ? 1'b1 : 1'b0;

  logic             sync_q1;
  logic             sync_q2;
  logic             pressed;
  logic [CNT_W-1:0] cnt;
  logic             state_q;
  logic             state_d1;
  logic             press_q;

  assign pressed = KEY_ACT_LOW ? ~sync_q2 : sync_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= KEY_REL;
      sync_q2 <= KEY_REL;
    end else begin
      sync_q1 <= key;
      sync_q2 <= sync_q1;
    end
  end

  // Count consecutive cycles the synchronised level disagrees with the
  // accepted level; any agreement restarts the count, so the counter stops
  // at CNT_LAST and cannot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      state_q <= 1'b0;
    end else if (pressed != state_q) begin
      if (cnt == CNT_LAST) begin
        state_q <= pressed;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  // Press strobe is registered from the accepted level, so it lands one
  // cycle after key_state rises; a falling edge produces nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_d1 <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      state_d1 <= state_q;
      press_q  <= state_q & ~state_d1;
    end
  end

  assign key_state = state_q;
  assign key_press = press_q;

endmodule

// File: rtl/key_led_ctrl.sv
// key_led_ctrl
//   Multi-channel push-button to LED controller. Each channel is debounced by
//   its own key_debounce instance; this level adds the shared blink
//   prescaler, the per-channel mode registers and the LED state machines.
// Ports
//   sys_clk    clock
//   sys_rst    synchronous active-high reset
//   key        raw key pins, one per channel
//   mode       per-channel mode, bits [2i+1:2i] for channel i
//   led        LED drive, 1 = lit
//   key_state  debounced level per channel, 1 = pressed
//   key_press  one-cycle press strobe per channel
module key_led_ctrl
  import key_led_pkg::*;
#(
  parameter int CH           = 4,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int BLINK_CYC    = 25_000_000,
  parameter bit KEY_ACT_LOW  = 1'b1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [CH-1:0]        key,
  input  logic [MODE_W*CH-1:0] mode,
  output logic [CH-1:0]        led,
  output logic [CH-1:0]        key_state,
  output logic [CH-1:0]        key_press
);

  localparam int BW = $clog2(BLINK_CYC);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

  // ---------------------------------------------------------------------------
  // Per-channel debounce
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < CH; g++) begin : g_ch
    key_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .KEY_ACT_LOW  (KEY_ACT_LOW)
    ) u_deb (
      .clk       (sys_clk),
      .rst       (sys_rst),
      .key       (key[g]),
      .key_state (key_state[g]),
      .key_press (key_press[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Shared blink prescaler: free-running from reset so every blinking channel
  // shows the same phase.
  // ---------------------------------------------------------------------------
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          blink_phase_n;

  assign blink_phase_n = (blink_cnt == BLINK_LAST) ? ~blink_phase : blink_phase;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      blink_cnt   <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
      blink_phase <= blink_phase_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Mode registers and LED state
  // ---------------------------------------------------------------------------
  logic [MODE_W*CH-1:0] mode_q;
  logic [CH-1:0]        tog_q;
  logic [CH-1:0]        tog_n;
  logic [CH-1:0]        ben_q;
  logic [CH-1:0]        ben_n;
  logic [CH-1:0]        led_q;
  logic [CH-1:0]        led_n;

  // A mode change wins over a same-cycle press: the channel restarts from a
  // clean state in its new mode, while the press strobe itself is untouched.
  // The LED is computed from the next-state toggle/blink bits so it reacts in
  // the same cycle those bits change.
  always_comb begin
    tog_n = tog_q;
    ben_n = ben_q;
    led_n = '0;
    for (int i = 0; i < CH; i++) begin
      if (mode[MODE_W*i +: MODE_W] != mode_q[MODE_W*i +: MODE_W]) begin
        tog_n[i] = 1'b0;
        ben_n[i] = 1'b0;
      end else if (key_press[i]) begin
        if (mode[MODE_W*i +: MODE_W] == MODE_TOGGLE) tog_n[i] = ~tog_q[i];
        if (mode[MODE_W*i +: MODE_W] == MODE_BLINK)  ben_n[i] = ~ben_q[i];
      end

      case (mode[MODE_W*i +: MODE_W])
        MODE_FOLLOW: led_n[i] = key_state[i];
        MODE_TOGGLE: led_n[i] = tog_n[i];
        MODE_BLINK:  led_n[i] = ben_n[i] & blink_phase_n;
        default:     led_n[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mode_q <= '0;
      tog_q  <= '0;
      ben_q  <= '0;
      led_q  <= '0;
    end else begin
      mode_q <= mode;
      tog_q  <= tog_n;
      ben_q  <= ben_n;
      led_q  <= led_n;
    end
  end

  assign led = led_q;

endmodule
